// File: rtl/seat_pkg.sv
// Shared types and default sizes for the classroom seat-assignment table.
// Op, status and FSM state encodings are fixed so the controller and display logic agree.
package seat_pkg;

    localparam int STUDENT_W_DEF = 25;
    localparam int SEAT_W_DEF    = 8;
    localparam int DEPTH_DEF     = 32;

    typedef enum logic [1:0] {
        OP_ASSIGN  = 2'd0,
        OP_RELEASE = 2'd1,
        OP_FIND    = 2'd2,
        OP_CLEAR   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        RSP_OK       = 2'd0,
        RSP_OCCUPIED = 2'd1,
        RSP_EMPTY    = 2'd2,
        RSP_MISS     = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_CLEAR  = 2'd2
    } state_e;

endpackage

// File: rtl/seat_if.sv
// Command/response handshake between the seating controller (master) and seat_table (slave).
interface seat_if
    import seat_pkg::*;
#(
    parameter int STUDENT_W = STUDENT_W_DEF,
    parameter int SEAT_W    = SEAT_W_DEF
);
    logic                 cmd_valid_seat;
    logic                 cmd_ready_seat;
    op_e                  cmd_op_seat;
    logic [SEAT_W-1:0]    cmd_seat_no;
    logic [STUDENT_W-1:0] cmd_student_no;
    logic                 rsp_valid_seat;
    status_e              rsp_status_seat;
    logic [SEAT_W-1:0]    rsp_seat_no;
    logic [STUDENT_W-1:0] rsp_student_no;

    modport master (
        output cmd_valid_seat, cmd_op_seat, cmd_seat_no, cmd_student_no,
        input  cmd_ready_seat, rsp_valid_seat, rsp_status_seat, rsp_seat_no, rsp_student_no
    );

    modport slave (
        input  cmd_valid_seat, cmd_op_seat, cmd_seat_no, cmd_student_no,
        output cmd_ready_seat, rsp_valid_seat, rsp_status_seat, rsp_seat_no, rsp_student_no
    );
endinterface

// File: rtl/seat_ram.sv
// Student-number storage: one write port, a combinational port for the FSM and a
// registered lookup port. Contents are not reset; the occupancy vector masks them.
module seat_ram #(
    parameter int STUDENT_W = 25,
    parameter int DEPTH     = 32,
    parameter int AW        = 5
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [STUDENT_W-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic [STUDENT_W-1:0] rdata,
    input  logic [AW-1:0]        rd_addr,
    output logic [STUDENT_W-1:0] rd_data
);

    logic [STUDENT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

    // Registered port samples the pre-write contents on a same-edge write.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/seat_table.sv
// Seat-to-student table for one classroom: assign/release/find/clear commands,
// occupancy tracking and an independent registered lookup port.
module seat_table
    import seat_pkg::*;
#(
    parameter int STUDENT_W       = STUDENT_W_DEF,
    parameter int SEAT_W          = SEAT_W_DEF,
    parameter int DEPTH           = DEPTH_DEF,
    parameter int ALLOW_OVERWRITE = 0
) (
    input  logic                         clk_seat,
    input  logic                         rst_seat,
    seat_if.slave                        bus,
    input  logic [SEAT_W-1:0]            rd_seat_no,
    output logic [STUDENT_W-1:0]         rd_student_no,
    output logic                         rd_occupied,
    output logic [$clog2(DEPTH+1)-1:0]   occ_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    state_e               state_q, state_d;
    logic [AW-1:0]        scan_q, scan_d;
    logic [STUDENT_W-1:0] key_q, key_d;
    logic [DEPTH-1:0]     occ_q, occ_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 rsp_valid_q, rsp_valid_d;
    status_e              rsp_status_q, rsp_status_d;
    logic [SEAT_W-1:0]    rsp_seat_q, rsp_seat_d;
    logic [STUDENT_W-1:0] rsp_student_q, rsp_student_d;
    logic                 rd_occ_q;

    logic                 we;
    logic [AW-1:0]        ram_raddr;
    logic [STUDENT_W-1:0] ram_rdata;
    logic [STUDENT_W-1:0] ram_rd_data;

    logic [AW-1:0]        cmd_idx;
    logic                 cmd_in_range;
    logic [AW-1:0]        rd_idx;
    logic                 rd_in_range;
    logic                 scan_last;

    assign cmd_idx      = bus.cmd_seat_no[AW-1:0];
    assign cmd_in_range = ({1'b0, bus.cmd_seat_no} < (SEAT_W+1)'(DEPTH));
    assign rd_idx       = rd_seat_no[AW-1:0];
    assign rd_in_range  = ({1'b0, rd_seat_no} < (SEAT_W+1)'(DEPTH));
    assign scan_last    = (scan_q == AW'(DEPTH-1));
    assign ram_raddr    = (state_q == S_IDLE) ? cmd_idx : scan_q;

    seat_ram #(
        .STUDENT_W (STUDENT_W),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_ram (
        .clk     (clk_seat),
        .we      (we),
        .waddr   (cmd_idx),
        .wdata   (bus.cmd_student_no),
        .raddr   (ram_raddr),
        .rdata   (ram_rdata),
        .rd_addr (rd_idx),
        .rd_data (ram_rd_data)
    );

    always_comb begin
        state_d       = state_q;
        scan_d        = scan_q;
        key_d         = key_q;
        occ_d         = occ_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_status_d  = rsp_status_q;
        rsp_seat_d    = rsp_seat_q;
        rsp_student_d = rsp_student_q;
        we            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid_seat) begin
                    // Echo operands up front; result fields override them below.
                    rsp_seat_d    = bus.cmd_seat_no;
                    rsp_student_d = bus.cmd_student_no;
                    case (bus.cmd_op_seat)
                        OP_ASSIGN: begin
                            rsp_valid_d = 1'b1;
                            if (!cmd_in_range) begin
                                rsp_status_d = RSP_MISS;
                            end else if (!occ_q[cmd_idx]) begin
                                we             = 1'b1;
                                occ_d[cmd_idx] = 1'b1;
                                cnt_d          = cnt_q + CW'(1);
                                rsp_status_d   = RSP_OK;
                            end else if (ALLOW_OVERWRITE != 0) begin
                                we           = 1'b1;
                                rsp_status_d = RSP_OK;
                            end else begin
                                rsp_status_d  = RSP_OCCUPIED;
                                rsp_student_d = ram_rdata;
                            end
                        end
                        OP_RELEASE: begin
                            rsp_valid_d = 1'b1;
                            if (!cmd_in_range) begin
                                rsp_status_d = RSP_MISS;
                            end else if (occ_q[cmd_idx]) begin
                                occ_d[cmd_idx] = 1'b0;
                                cnt_d          = cnt_q - CW'(1);
                                rsp_status_d   = RSP_OK;
                                rsp_student_d  = ram_rdata;
                            end else begin
                                rsp_status_d = RSP_EMPTY;
                            end
                        end
                        OP_FIND: begin
                            key_d   = bus.cmd_student_no;
                            scan_d  = '0;
                            state_d = S_SEARCH;
                        end
                        default: begin
                            scan_d  = '0;
                            state_d = S_CLEAR;
                        end
                    endcase
                end
            end
            S_SEARCH: begin
                if (occ_q[scan_q] && (ram_rdata == key_q)) begin
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = RSP_OK;
                    rsp_seat_d   = SEAT_W'(scan_q);
                    state_d      = S_IDLE;
                end else if (scan_last) begin
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = RSP_MISS;
                    rsp_seat_d   = '0;
                    state_d      = S_IDLE;
                end else begin
                    scan_d = scan_q + AW'(1);
                end
            end
            S_CLEAR: begin
                if (occ_q[scan_q]) begin
                    occ_d[scan_q] = 1'b0;
                    cnt_d         = cnt_q - CW'(1);
                end
                if (scan_last) begin
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = RSP_OK;
                    state_d      = S_IDLE;
                end else begin
                    scan_d = scan_q + AW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_seat or posedge rst_seat) begin
        if (rst_seat) begin
            state_q       <= S_IDLE;
            scan_q        <= '0;
            key_q         <= '0;
            occ_q         <= '0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_status_q  <= RSP_OK;
            rsp_seat_q    <= '0;
            rsp_student_q <= '0;
            rd_occ_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            scan_q        <= scan_d;
            key_q         <= key_d;
            occ_q         <= occ_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_status_q  <= rsp_status_d;
            rsp_seat_q    <= rsp_seat_d;
            rsp_student_q <= rsp_student_d;
            rd_occ_q      <= rd_in_range && occ_q[rd_idx];
        end
    end

    assign bus.cmd_ready_seat  = (state_q == S_IDLE);
    assign bus.rsp_valid_seat  = rsp_valid_q;
    assign bus.rsp_status_seat = rsp_status_q;
    assign bus.rsp_seat_no     = rsp_seat_q;
    assign bus.rsp_student_no  = rsp_student_q;
    assign occ_count           = cnt_q;
    assign rd_occupied         = rd_occ_q;
    assign rd_student_no       = rd_occ_q ? ram_rd_data : '0;

endmodule

// File: tb/tb_seat_table.sv
// Bench for seat_table: two instances (overwrite off/on) driven in lockstep and compared
// against an array-based model of the seating rules, directed steps then random commands.
module tb_seat_table;
    import seat_pkg::*;

    localparam int SW = 25;
    localparam int NW = 8;
    localparam int D  = 32;
    localparam int CW = $clog2(D+1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seat_if #(.STUDENT_W(SW), .SEAT_W(NW)) b0 ();
    seat_if #(.STUDENT_W(SW), .SEAT_W(NW)) b1 ();

    logic [NW-1:0] rd_seat;
    logic [SW-1:0] rd_stu0, rd_stu1;
    logic          rd_occ0, rd_occ1;
    logic [CW-1:0] cnt0, cnt1;

    seat_table #(.STUDENT_W(SW), .SEAT_W(NW), .DEPTH(D), .ALLOW_OVERWRITE(0)) dut0 (
        .clk_seat(clk), .rst_seat(rst), .bus(b0), .rd_seat_no(rd_seat),
        .rd_student_no(rd_stu0), .rd_occupied(rd_occ0), .occ_count(cnt0));

    seat_table #(.STUDENT_W(SW), .SEAT_W(NW), .DEPTH(D), .ALLOW_OVERWRITE(1)) dut1 (
        .clk_seat(clk), .rst_seat(rst), .bus(b1), .rd_seat_no(rd_seat),
        .rd_student_no(rd_stu1), .rd_occupied(rd_occ1), .occ_count(cnt1));

    int checks   = 0;
    int failures = 0;

    bit            occ_m [2][D];
    logic [SW-1:0] dat_m [2][D];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_cnt(input int d);
        int n = 0;
        for (int i = 0; i < D; i++) n += occ_m[d][i] ? 1 : 0;
        return n;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < D; i++) occ_m[d][i] = 1'b0;
    endtask

    task automatic model_step(input int d, input op_e op, input logic [NW-1:0] seat,
                              input logic [SW-1:0] stu, output int lat, output status_e st,
                              output logic [NW-1:0] sn, output logic [SW-1:0] su);
        int k;
        bit in_r;
        in_r = (int'(seat) < D);
        lat  = 1;
        st   = RSP_OK;
        sn   = seat;
        su   = stu;
        case (op)
            OP_ASSIGN: begin
                if (!in_r) st = RSP_MISS;
                else if (!occ_m[d][seat]) begin
                    occ_m[d][seat] = 1'b1;
                    dat_m[d][seat] = stu;
                end else if (d == 1) dat_m[d][seat] = stu;
                else begin
                    st = RSP_OCCUPIED;
                    su = dat_m[d][seat];
                end
            end
            OP_RELEASE: begin
                if (!in_r) st = RSP_MISS;
                else if (occ_m[d][seat]) begin
                    occ_m[d][seat] = 1'b0;
                    su = dat_m[d][seat];
                end else st = RSP_EMPTY;
            end
            OP_FIND: begin
                k = -1;
                for (int i = D - 1; i >= 0; i--)
                    if (occ_m[d][i] && dat_m[d][i] == stu) k = i;
                if (k >= 0) begin
                    lat = 2 + k;
                    sn  = NW'(k);
                end else begin
                    lat = 1 + D;
                    st  = RSP_MISS;
                    sn  = '0;
                end
            end
            default: begin
                lat = 1 + D;
                for (int i = 0; i < D; i++) occ_m[d][i] = 1'b0;
            end
        endcase
    endtask

    task automatic drive(input logic v, input op_e op, input logic [NW-1:0] seat,
                         input logic [SW-1:0] stu);
        b0.cmd_valid_seat = v; b0.cmd_op_seat = op; b0.cmd_seat_no = seat; b0.cmd_student_no = stu;
        b1.cmd_valid_seat = v; b1.cmd_op_seat = op; b1.cmd_seat_no = seat; b1.cmd_student_no = stu;
    endtask

    // Called at a negedge with both instances idle; returns at a negedge.
    task automatic run_cmd(input string tag, input op_e op, input logic [NW-1:0] seat,
                           input logic [SW-1:0] stu);
        int            exp_lat [2];
        int            obs_lat [2];
        status_e       exp_st [2], obs_st [2];
        logic [NW-1:0] exp_sn [2], obs_sn [2];
        logic [SW-1:0] exp_su [2], obs_su [2];
        bit            rdy_bad [2];
        int            maxlat;
        logic          v, r;
        status_e       st;
        logic [NW-1:0] sn;
        logic [SW-1:0] su;
        for (int d = 0; d < 2; d++) begin
            model_step(d, op, seat, stu, exp_lat[d], exp_st[d], exp_sn[d], exp_su[d]);
            obs_lat[d] = 0; obs_st[d] = RSP_OK; obs_sn[d] = '0; obs_su[d] = '0;
        end
        rdy_bad[0] = (b0.cmd_ready_seat !== 1'b1);
        rdy_bad[1] = (b1.cmd_ready_seat !== 1'b1);
        maxlat = ((exp_lat[0] > exp_lat[1]) ? exp_lat[0] : exp_lat[1]) + 2;
        drive(1'b1, op, seat, stu);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, op, seat, stu);
        for (int c = 1; c <= maxlat; c++) begin
            if (c > 1) @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (d == 0) begin
                    v = b0.rsp_valid_seat; r = b0.cmd_ready_seat; st = b0.rsp_status_seat;
                    sn = b0.rsp_seat_no; su = b0.rsp_student_no;
                end else begin
                    v = b1.rsp_valid_seat; r = b1.cmd_ready_seat; st = b1.rsp_status_seat;
                    sn = b1.rsp_seat_no; su = b1.rsp_student_no;
                end
                if (v === 1'b1) begin
                    if (obs_lat[d] == 0) begin
                        obs_lat[d] = c; obs_st[d] = st; obs_sn[d] = sn; obs_su[d] = su;
                    end else obs_lat[d] = -1;
                end
                if (r !== (c >= exp_lat[d])) rdy_bad[d] = 1'b1;
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_d%0d_latency", tag, d), obs_lat[d], exp_lat[d]);
            chk($sformatf("%s_d%0d_status", tag, d), obs_st[d], exp_st[d]);
            chk($sformatf("%s_d%0d_rsp_seat", tag, d), obs_sn[d], exp_sn[d]);
            chk($sformatf("%s_d%0d_rsp_student", tag, d), obs_su[d], exp_su[d]);
            chk($sformatf("%s_d%0d_ready_bad", tag, d), rdy_bad[d], 0);
            chk($sformatf("%s_d%0d_occ_count", tag, d), (d == 0) ? cnt0 : cnt1, model_cnt(d));
        end
    endtask

    task automatic rd_check(input string tag, input logic [NW-1:0] seat);
        logic [SW-1:0] es;
        bit            eo;
        rd_seat = seat;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            eo = 1'b0;
            es = '0;
            if (int'(seat) < D && occ_m[d][seat]) begin
                eo = 1'b1;
                es = dat_m[d][seat];
            end
            chk($sformatf("%s_d%0d_rd_occ", tag, d), (d == 0) ? rd_occ0 : rd_occ1, eo);
            chk($sformatf("%s_d%0d_rd_stu", tag, d), (d == 0) ? rd_stu0 : rd_stu1, es);
        end
    endtask

    initial begin
        logic [NW-1:0] s;
        logic [SW-1:0] u;
        int            r;
        bit            pulse;

        rst = 1'b1;
        rd_seat = '0;
        drive(1'b0, OP_ASSIGN, '0, '0);
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset_ready", b0.cmd_ready_seat, 1);
        chk("reset_rsp_valid", b0.rsp_valid_seat, 0);
        chk("reset_rsp_status", b0.rsp_status_seat, RSP_OK);
        chk("reset_rsp_seat", b0.rsp_seat_no, 0);
        chk("reset_rsp_student", b0.rsp_student_no, 0);
        chk("reset_occ_count", cnt0, 0);
        rd_check("reset_rd", 8'd0);

        run_cmd("assign5", OP_ASSIGN, 8'd5, 25'd2023001);
        rd_check("rd5_a", 8'd5);
        run_cmd("assign5_again", OP_ASSIGN, 8'd5, 25'd2023002);
        rd_check("rd5_b", 8'd5);
        run_cmd("release7", OP_RELEASE, 8'd7, 25'd0);
        run_cmd("release40", OP_RELEASE, 8'd40, 25'd0);
        run_cmd("assign40", OP_ASSIGN, 8'd40, 25'd1);
        rd_check("rd40", 8'd40);
        run_cmd("release5", OP_RELEASE, 8'd5, 25'd0);
        run_cmd("assign3", OP_ASSIGN, 8'd3, 25'd9);
        run_cmd("assign20", OP_ASSIGN, 8'd20, 25'd9);
        run_cmd("find9", OP_FIND, 8'd0, 25'd9);
        run_cmd("find10", OP_FIND, 8'd0, 25'd10);
        run_cmd("assign31", OP_ASSIGN, 8'd31, 25'd4);
        run_cmd("find_last", OP_FIND, 8'd0, 25'd4);

        run_cmd("clear0", OP_CLEAR, 8'd0, 25'd0);
        for (int i = 0; i < D; i++) run_cmd("fill", OP_ASSIGN, NW'(i), SW'(100 + i));
        run_cmd("clear_full", OP_CLEAR, 8'd0, 25'd0);
        for (int i = 0; i < D; i++) rd_check("rd_after_clear", NW'(i));

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            s = NW'($urandom_range(0, 40));
            u = SW'($urandom_range(1, 6));
            if (r < 45)      run_cmd("rnd_assign", OP_ASSIGN, s, u);
            else if (r < 70) run_cmd("rnd_release", OP_RELEASE, s, u);
            else if (r < 96) run_cmd("rnd_find", OP_FIND, s, u);
            else             run_cmd("rnd_clear", OP_CLEAR, s, u);
            if (n % 5 == 0) rd_check("rnd_rd", NW'($urandom_range(0, 40)));
        end

        // Reset ten cycles into a search that would otherwise miss after 33 cycles.
        run_cmd("pre_rst_assign", OP_ASSIGN, 8'd2, 25'd77);
        pulse = 1'b0;
        drive(1'b1, OP_FIND, 8'd0, 25'd999);
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            drive(1'b0, OP_FIND, 8'd0, 25'd999);
            if (b0.rsp_valid_seat === 1'b1 || b1.rsp_valid_seat === 1'b1) pulse = 1'b1;
        end
        #2 rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (b0.rsp_valid_seat === 1'b1 || b1.rsp_valid_seat === 1'b1) pulse = 1'b1;
        end
        rst = 1'b0;
        model_clear();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (b0.rsp_valid_seat === 1'b1 || b1.rsp_valid_seat === 1'b1) pulse = 1'b1;
        end
        chk("midrst_no_pulse", pulse, 0);
        chk("midrst_ready0", b0.cmd_ready_seat, 1);
        chk("midrst_ready1", b1.cmd_ready_seat, 1);
        chk("midrst_cnt0", cnt0, 0);
        chk("midrst_cnt1", cnt1, 0);
        rd_check("midrst_rd", 8'd2);
        run_cmd("post_rst_find", OP_FIND, 8'd0, 25'd77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seat_table.md
# seat_table

Parametrised seat-assignment table that maps seat numbers to student numbers. It adds per-seat occupancy tracking, a command/response handshake, occupancy-conflict detection, release, reverse lookup (student → seat) and a bulk clear. It sits between the seating controller FSM and the display/lookup logic, and is the storage element for one classroom.

## Interface
Parameters:
- STUDENT_W, 25, student-number width
- SEAT_W, 8, seat-number width
- DEPTH, 32, number of seats (DEPTH ≤ 2**SEAT_W); seats DEPTH..2**SEAT_W-1 are out of range
- ALLOW_OVERWRITE, 0, 1 = ASSIGN to an occupied seat overwrites it

Ports:
- clk_seat  in  1  clock; all state updates on the rising edge
- rst_seat  in  1  reset, asynchronous, active-high
- cmd_valid_seat  in  1  command request
- cmd_ready_seat  out  1  block can accept a command
- cmd_op_seat  in  2  operation code: ASSIGN, RELEASE, FIND or CLEAR
- cmd_seat_no  in  SEAT_W  seat operand (ASSIGN, RELEASE)
- cmd_student_no  in  STUDENT_W  student operand (ASSIGN, FIND)
- rsp_valid_seat  out  1  one-cycle response pulse; no backpressure
- rsp_status_seat  out  2  response status: OK, OCCUPIED, EMPTY or MISS
- rsp_seat_no  out  SEAT_W  seat result or echo
- rsp_student_no  out  STUDENT_W  student result or echo
- rd_seat_no  in  SEAT_W  independent lookup address
- rd_student_no  out  STUDENT_W  registered lookup data; 0 if the seat is unoccupied or out of range
- rd_occupied  out  1  registered occupancy bit of rd_seat_no
- occ_count  out  $clog2(DEPTH+1)  number of occupied seats

## Operation
- Storage is DEPTH×STUDENT_W data plus a DEPTH-bit occupancy vector.
- Data RAM is not reset. Occupancy masks it.
- A command is accepted when cmd_valid_seat && cmd_ready_seat.
- cmd_ready_seat = (state == IDLE).
- FSM states: IDLE, SEARCH, CLEAR.
- ASSIGN (IDLE, single cycle):
  - Seat out of range → MISS, no change.
  - Seat free → write data, set occupancy, occ_count+1, OK.
  - Seat occupied and ALLOW_OVERWRITE=0 → OCCUPIED, no change. rsp_student_no = current occupant.
  - Seat occupied and ALLOW_OVERWRITE=1 → overwrite, OK, count unchanged.
- RELEASE (IDLE, single cycle):
  - Seat occupied → clear occupancy, occ_count-1, OK. rsp_student_no = released occupant.
  - Seat free → EMPTY.
  - Seat out of range → MISS.
- FIND: IDLE→SEARCH.
  - Scan index i = 0,1,… one seat per cycle.
  - Hit = occupied[i] && data[i] == cmd_student_no (latched at accept). Lowest index wins.
  - Hit → OK, rsp_seat_no = i, return to IDLE.
  - Index DEPTH-1 examined with no hit → MISS, rsp_seat_no = 0, return to IDLE.
- CLEAR: IDLE→CLEAR.
  - Clear occupancy of one seat per cycle, index 0..DEPTH-1.
  - Decrement occ_count for each seat that was occupied.
  - After index DEPTH-1 → OK, return to IDLE.
- Response echo: rsp_seat_no / rsp_student_no echo the operands except where a result is defined above.
- occ_count saturates neither way; it is consistent by construction (0..DEPTH).
- Unknown or X op is not possible: the 2-bit op is fully decoded.

## Timing
- Reset values:
  - state IDLE, cmd_ready_seat 1 once reset is deasserted
  - occupancy all 0, occ_count 0
  - rsp_valid_seat 0, rsp_status_seat OK, rsp_seat_no 0, rsp_student_no 0
  - rd_student_no 0, rd_occupied 0
- Command accepted at edge N:
  - ASSIGN/RELEASE: response pulse in cycle N+1. Ready stays high, so back-to-back commands are accepted.
  - FIND with hit at index k: response in cycle N+2+k. Ready low from N+1 until the response cycle. Ready is high in the response cycle.
  - FIND with no hit: response in cycle N+1+DEPTH.
  - CLEAR: response in cycle N+1+DEPTH.
- Read port: rd_student_no / rd_occupied valid one cycle after rd_seat_no is sampled.
- Read port during a same-cycle write to the same seat: returns the old value (read-before-write).
- Read port during CLEAR/SEARCH: sees the live table state.
- Asynchronous reset mid-SEARCH or mid-CLEAR: aborts immediately, no response pulse, all state takes its reset values.
- cmd inputs are ignored while cmd_ready_seat = 0.

## Structure
- Package seat_pkg holds:
  - op enum: ASSIGN=2'd0, RELEASE=2'd1, FIND=2'd2, CLEAR=2'd3
  - status enum: OK=2'd0, OCCUPIED=2'd1, EMPTY=2'd2, MISS=2'd3
  - FSM state enum
  - default width constants
- Sub-module seat_ram:
  - DEPTH×STUDENT_W
  - one synchronous write port
  - one combinational read port for the FSM
  - one registered read port for rd_*
- Occupancy vector, counter and FSM live in seat_table.

## Test plan
- Reset, then ASSIGN seat 5 / student 25'd2023001 → next cycle rsp OK, occ_count 1. rd_seat_no=5 → rd_student_no 2023001, rd_occupied 1.
- ASSIGN seat 5 / student 2023002 with ALLOW_OVERWRITE=0 → OCCUPIED, rsp_student_no 2023001, occ_count 1. Repeat with ALLOW_OVERWRITE=1 → OK, data 2023002.
- RELEASE seat 7 (free) → EMPTY. RELEASE seat 40 (DEPTH 32) → MISS. RELEASE seat 5 → OK, occ_count 0.
- Assign student 9 to seats 3 and 20, then FIND 9 → rsp at N+5, OK, seat 3. FIND 10 → MISS at N+33.
- Fill all 32 seats, then CLEAR → ready low for 32 cycles, OK at N+33, occ_count 0, every rd_occupied 0.
- Assert reset at cycle N+10 of a FIND → no rsp_valid pulse, cmd_ready_seat high after release of reset, occ_count 0.
